// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// System reset controller for the 4004 SCU. It takes the board push-button
// (raw, asynchronous, active-low, bouncing), synchronises and debounces it, and
// merges it with the synchronous system reset and an optional software reset
// request. From these sources it drives NUM_DOM registered, active-high domain
// resets. All domains assert together and are released one at a time, in index
// order (bit 0 first), once the hold time has elapsed.
//
// Parameters
//   NUM_DOM      number of reset domains (1..16)
//   DBNC_CYCLES  consecutive stable samples needed to accept a button change
//   HOLD_CYCLES  cycles all domains stay asserted after the last source clears
//   GAP_CYCLES   cycles between successive domain releases
//
// Ports
//   clk_i         in   system clock
//   rst_i         in   synchronous active-high system (power-on) reset
//   btn_rstn_i    in   raw push-button reset, active-low, asynchronous
//   sw_rst_req_i  in   software reset request, active-high, one cycle
//   rst_o         out  [NUM_DOM-1:0] domain resets, active-high
//   rst_done_o    out  high while every domain is released
//   rst_cause_o   out  [1:0] cause of last reset: 00 system, 01 button,
//                      10 software
//
// Build option
//   SCU_SW_RST_EN  when defined, sw_rst_req_i triggers a reset and cause code
//                  10 becomes reachable. When undefined the request input is
//                  ignored and no logic is built for it.
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int DBNC_CYCLES = 10,
    parameter int HOLD_CYCLES = 100,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btn_rstn_i,
    input  logic               sw_rst_req_i,
    output logic [NUM_DOM-1:0] rst_o,
    output logic               rst_done_o,
    output logic [1:0]         rst_cause_o
);

    localparam int DBNC_W = $clog2(DBNC_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W  = $clog2(NUM_DOM + 1);

    localparam logic [1:0] CAUSE_SYS = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Button path: two-flop synchroniser followed by a debounce counter.
    // btn_state_reg is the accepted level (1 = released). The counter tracks
    // how many consecutive synchronised samples disagree with it; any agreeing
    // sample clears it, so a bounce restarts the count.
    // -------------------------------------------------------------------------
    logic              sync1_reg;
    logic              sync2_reg;
    logic              btn_state_reg;
    logic              press_evt_reg;
    logic [DBNC_W-1:0] dbnc_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            btn_state_reg <= 1'b1;
            dbnc_cnt_reg  <= '0;
            press_evt_reg <= 1'b0;
        end else begin
            sync1_reg     <= btn_rstn_i;
            sync2_reg     <= sync1_reg;
            press_evt_reg <= 1'b0;
            if (sync2_reg == btn_state_reg) begin
                dbnc_cnt_reg <= '0;
            end else if (dbnc_cnt_reg >= DBNC_W'(DBNC_CYCLES - 1)) begin
                // This sample is the DBNC_CYCLES-th disagreeing one: accept it.
                btn_state_reg <= sync2_reg;
                dbnc_cnt_reg  <= '0;
                // Only the transition into "pressed" is an event.
                press_evt_reg <= ~sync2_reg;
            end else begin
                dbnc_cnt_reg <= dbnc_cnt_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Software request path (optional)
    // -------------------------------------------------------------------------
    logic sw_req;

`ifdef SCU_SW_RST_EN
    assign sw_req = sw_rst_req_i;
`else
    assign sw_req = 1'b0;
    // Port kept for pin compatibility; deliberately not used.
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req_i;
`endif

    // -------------------------------------------------------------------------
    // Sequencer state and registered outputs
    // -------------------------------------------------------------------------
    state_t             state_reg,    state_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg,  gap_cnt_next;
    logic [IDX_W-1:0]   idx_reg,      idx_next;
    logic [NUM_DOM-1:0] rst_reg,      rst_next;
    logic               done_reg,     done_next;
    logic [1:0]         cause_reg,    cause_next;

    logic               trigger;
    logic [NUM_DOM-1:0] idx_hit;

    // One-hot decode of the next domain to release.
    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_idx_hit
            assign idx_hit[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // A press event and a software request both restart the sequence.
    assign trigger = press_evt_reg | sw_req;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_ASSERT;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            idx_reg      <= '0;
            rst_reg      <= '1;
            done_reg     <= 1'b0;
            cause_reg    <= CAUSE_SYS;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            idx_reg      <= idx_next;
            rst_reg      <= rst_next;
            done_reg     <= done_next;
            cause_reg    <= cause_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        idx_next      = idx_reg;
        rst_next      = rst_reg;
        done_next     = done_reg;
        cause_next    = cause_reg;

        // Button has priority over software when both arrive together.
        if (press_evt_reg) begin
            cause_next = CAUSE_BTN;
        end else if (sw_req) begin
            cause_next = CAUSE_SW;
        end

        case (state_reg)
            ST_ASSERT: begin
                rst_next  = '1;
                done_next = 1'b0;
                if (trigger || !btn_state_reg) begin
                    // New request, or button still held: hold time restarts.
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg >= HOLD_W'(HOLD_CYCLES - 1)) begin
                    // Hold expires on this edge: domain 0 goes first.
                    hold_cnt_next = HOLD_W'(HOLD_CYCLES);
                    gap_cnt_next  = '0;
                    idx_next      = IDX_W'(1);
                    rst_next[0]   = 1'b0;
                    if (NUM_DOM == 1) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (trigger) begin
                    state_next    = ST_ASSERT;
                    rst_next      = '1;
                    done_next     = 1'b0;
                    hold_cnt_next = '0;
                    gap_cnt_next  = '0;
                    idx_next      = '0;
                end else if (gap_cnt_reg >= GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_next = '0;
                    rst_next     = rst_reg & ~idx_hit;
                    if (idx_reg >= IDX_W'(NUM_DOM - 1)) begin
                        // Last domain released: done rises on the same edge.
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            ST_RUN: begin
                rst_next  = '0;
                done_next = 1'b1;
                if (trigger) begin
                    state_next    = ST_ASSERT;
                    rst_next      = '1;
                    done_next     = 1'b0;
                    hold_cnt_next = '0;
                    gap_cnt_next  = '0;
                    idx_next      = '0;
                end
            end

            default: begin
                // Unused encoding: fall back to the safe, all-asserted state.
                state_next    = ST_ASSERT;
                rst_next      = '1;
                done_next     = 1'b0;
                hold_cnt_next = '0;
                gap_cnt_next  = '0;
                idx_next      = '0;
            end
        endcase
    end

    assign rst_o       = rst_reg;
    assign rst_done_o  = done_reg;
    assign rst_cause_o = cause_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Self-checking bench for rst_seq_ctrl at default parameters. A behavioural
// model tracks, per clock edge, the edge at which domain 0 must release and
// derives the expected outputs arithmetically from it; the button filter is
// modelled as a window over the raw sample history. A compare process checks
// every cycle, and directed literal checks pin key edges.
// Works with SCU_SW_RST_EN defined or undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

    localparam int NUM_DOM = 4;
    localparam int DBNC    = 10;
    localparam int HOLD    = 100;
    localparam int GAP     = 8;
    localparam int INF     = 32'h3fff_ffff;
    localparam int HIST_N  = 16384;

`ifdef SCU_SW_RST_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               btn = 1'b1;
    logic               sw = 1'b0;
    logic [NUM_DOM-1:0] rst_o;
    logic               done;
    logic [1:0]         cause;

    rst_seq_ctrl #(
        .NUM_DOM    (NUM_DOM),
        .DBNC_CYCLES(DBNC),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .btn_rstn_i  (btn),
        .sw_rst_req_i(sw),
        .rst_o       (rst_o),
        .rst_done_o  (done),
        .rst_cause_o (cause)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, cyc);
    endtask

    // ---------------------------------------------------------------- model
    bit                 hist [0:HIST_N-1];
    bit                 m_valid = 1'b0;
    bit                 acc = 1'b1;        // accepted button level, 1 = released
    bit                 press_pend = 1'b0;
    int                 last_flip = 0;
    int                 r_last = 0;
    int                 rel_start = INF;   // edge at which rst_o[0] must fall
    logic [1:0]         m_cause = 2'b00;
    logic [NUM_DOM-1:0] exp_rst = '1;
    logic               exp_done = 1'b0;

    // Value seen by the filter for raw sample idx (forced released by reset).
    function automatic bit eff(input int idx);
        if (idx <= r_last) return 1'b1;
        return hist[idx];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= HIST_N) begin
                $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HIST_N);
                $fatal(1);
            end
            hist[cyc] = btn;
            if (rst_i) begin
                m_valid    = 1'b1;
                acc        = 1'b1;
                press_pend = 1'b0;
                last_flip  = cyc;
                r_last     = cyc;
                m_cause    = 2'b00;
                rel_start  = cyc + HOLD;
            end else if (m_valid) begin
                bit was_pressed;
                bit stable;
                was_pressed = !acc;
                if (press_pend) begin
                    m_cause   = 2'b01;
                    rel_start = INF;
                end else if (SW_EN && sw) begin
                    m_cause   = 2'b10;
                    rel_start = was_pressed ? INF : cyc + HOLD;
                end
                press_pend = 1'b0;
                // Accept a change once the last DBNC filter inputs since the
                // previous acceptance all oppose the accepted level.
                stable = 1'b1;
                for (int j = 0; j < DBNC; j++) begin
                    int idx;
                    idx = cyc - 2 - j;
                    if (idx <= last_flip - 2) stable = 1'b0;
                    else if (eff(idx) == acc) stable = 1'b0;
                end
                if (stable) begin
                    acc       = !acc;
                    last_flip = cyc;
                    if (!acc) press_pend = 1'b1;
                    else      rel_start  = cyc + HOLD;
                end
            end
            // Expected outputs after this edge.
            begin
                int k;
                k = (cyc < rel_start) ? 0 : (cyc - rel_start) / GAP + 1;
                exp_rst  = '1;
                for (int b = 0; b < NUM_DOM; b++) if (b < k) exp_rst[b] = 1'b0;
                exp_done = (k >= NUM_DOM);
            end
        end
    end

    // -------------------------------------------------------------- compare
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("cyc_rst_o", rst_o, exp_rst);
                check("cyc_rst_done_o", done, exp_done);
                check("cyc_rst_cause_o", cause, m_cause);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at edge %0d", cyc);
        $fatal(1);
    end

    task automatic wait_edge(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int c0, c1, c2, c3, c4, c5, c6, c7, c8;
        rst_i = 1'b1; btn = 1'b1; sw = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rst_o", rst_o, 4'b1111);
        check("reset_done", done, 1'b0);
        check("reset_cause", cause, 2'b00);

        // Power-up release sequence.
        rst_i = 1'b0; c0 = cyc;
        wait_edge(c0 + 99);  check("pu_e99", rst_o, 4'b1111);
        wait_edge(c0 + 100); check("pu_e100", rst_o, 4'b1110);
        wait_edge(c0 + 108); check("pu_e108", rst_o, 4'b1100);
        wait_edge(c0 + 116); check("pu_e116", rst_o, 4'b1000);
        wait_edge(c0 + 123); check("pu_e123_done", done, 1'b0);
        wait_edge(c0 + 124); check("pu_e124", rst_o, 4'b0000);
        check("pu_e124_done", done, 1'b1);
        check("pu_cause", cause, 2'b00);

        // Bounce in RUN: must be filtered out.
        wait_edge(c0 + 130);
        btn = 1'b0; repeat (6) @(negedge clk);
        btn = 1'b1; repeat (3) @(negedge clk);
        btn = 1'b0; repeat (6) @(negedge clk);
        btn = 1'b1; repeat (20) @(negedge clk);
        check("bounce_rst_o", rst_o, 4'b0000);
        check("bounce_done", done, 1'b1);

        // Stable press of 20 cycles.
        btn = 1'b0; c1 = cyc;
        wait_edge(c1 + 12); check("press_e12", rst_o, 4'b0000);
        wait_edge(c1 + 13); check("press_e13", rst_o, 4'b1111);
        check("press_cause", cause, 2'b01);
        wait_edge(c1 + 20); btn = 1'b1; c2 = cyc;
        wait_edge(c2 + 111); check("rel_e111", rst_o, 4'b1111);
        wait_edge(c2 + 112); check("rel_e112", rst_o, 4'b1110);
        wait_edge(c2 + 136); check("rel_done", done, 1'b1);

        // Button held 500 cycles.
        wait_edge(c2 + 140);
        btn = 1'b0; c3 = cyc;
        wait_edge(c3 + 300); check("held_e300", rst_o, 4'b1111);
        wait_edge(c3 + 500); btn = 1'b1; c4 = cyc;
        wait_edge(c4 + 111); check("held_rel_e111", rst_o, 4'b1111);
        wait_edge(c4 + 112); check("held_rel_e112", rst_o, 4'b1110);
        wait_edge(c4 + 136); check("held_rel_done", done, 1'b1);

        // Press event and software request on the same edge: button wins.
        wait_edge(c4 + 140);
        btn = 1'b0; c5 = cyc;
        wait_edge(c5 + 12); sw = 1'b1;
        wait_edge(c5 + 13); sw = 1'b0;
        check("sim_rst_o", rst_o, 4'b1111);
        check("sim_cause", cause, 2'b01);
        btn = 1'b1; c6 = cyc;
        wait_edge(c6 + 140); check("sim_done", done, 1'b1);

        // Same again with rst_i on that edge: system reset overrides.
        btn = 1'b0; c7 = cyc;
        wait_edge(c7 + 12); sw = 1'b1; rst_i = 1'b1;
        wait_edge(c7 + 13); sw = 1'b0; rst_i = 1'b0; btn = 1'b1;
        check("simrst_rst_o", rst_o, 4'b1111);
        check("simrst_done", done, 1'b0);
        check("simrst_cause", cause, 2'b00);
        c8 = cyc;
        wait_edge(c8 + 124); check("simrst_done_after", done, 1'b1);

`ifdef SCU_SW_RST_EN
        // Software request in the middle of the release sequence.
        begin
            int c9;
            rst_i = 1'b1; @(negedge clk); rst_i = 1'b0; c9 = cyc;
            wait_edge(c9 + 110); check("mid_e110", rst_o, 4'b1100);
            sw = 1'b1;
            wait_edge(c9 + 111); sw = 1'b0;
            check("mid_e111", rst_o, 4'b1111);
            check("mid_cause", cause, 2'b10);
            wait_edge(c9 + 210); check("mid_e210", rst_o, 4'b1111);
            wait_edge(c9 + 211); check("mid_e211", rst_o, 4'b1110);
            wait_edge(c9 + 235); check("mid_done", done, 1'b1);
        end
`else
        // Software request must be ignored when the feature is not built.
        wait_edge(c8 + 130);
        sw = 1'b1; repeat (50) @(negedge clk); sw = 1'b0;
        check("swoff_rst_o", rst_o, 4'b0000);
        check("swoff_done", done, 1'b1);
        check("swoff_cause", cause, 2'b00);
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
